ppu_video_timing: RTL and testbench

//  - Raster timing generator directly upstream of the ppu pixel fetch stage: drives x_view/y_view per clock.
//  - Realigns the ppu's registered 16-bit colour with delayed sync/data-enable and emits the display pixel stream.
//  - Flags vblank so the CPU side can update VRAM/offsets between frames. One pixel per clk.

---
 rtl/ppu_video_timing.sv | 137 +++++++++++++
 tb/tb_ppu_video_timing.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_video_timing.sv
// Raster timing generator for the ppu: drives x_view/y_view, realigns ppu colour with delayed sync/DE.
// Optional define PPU_LINE_IRQ_EN adds the lyc compare port and line_irq pulse.
module ppu_video_timing #(
    parameter int H_ACTIVE    = 160,
    parameter int H_FRONT     = 8,
    parameter int H_SYNC      = 16,
    parameter int H_BACK      = 16,
    parameter int V_ACTIVE    = 144,
    parameter int V_FRONT     = 2,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 8,
    parameter int PPU_LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic [7:0]  x_view,
    output logic [7:0]  y_view,
    input  logic [15:0] colour_in,
    output logic [15:0] rgb_out,
    output logic        de,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        vblank,
`ifdef PPU_LINE_IRQ_EN
    input  logic [7:0]  lyc,
    output logic        line_irq,
`endif
    output logic        vblank_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int HS_BEG  = H_ACTIVE + H_FRONT;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FRONT;
    localparam int VS_END  = VS_BEG + V_SYNC;

    logic [HW-1:0] h_cnt_reg, h_cnt_next;
    logic [VW-1:0] v_cnt_reg, v_cnt_next;
    logic          run_reg;
    logic [7:0]    x_view_reg, y_view_reg;
    logic          clear;
    logic          active_raw, hs_raw, vs_raw;
    logic [2:0]    pipe_out;
    logic [15:0]   rgb_reg;
    logic          de_reg, hsync_n_reg, vsync_n_reg;

    assign clear = !rst_n || !enable;

    // run_reg holds the counters at (0,0) for the first enabled clock so that
    // position is presented once to the ppu before the raster advances.
    always_comb begin
        h_cnt_next = h_cnt_reg;
        v_cnt_next = v_cnt_reg;
        if (run_reg) begin
            if (int'(h_cnt_reg) == H_TOTAL - 1) begin
                h_cnt_next = '0;
                v_cnt_next = (int'(v_cnt_reg) == V_TOTAL - 1) ? '0 : v_cnt_reg + 1'b1;
            end else begin
                h_cnt_next = h_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            run_reg    <= 1'b0;
            h_cnt_reg  <= '0;
            v_cnt_reg  <= '0;
            x_view_reg <= 8'd0;
            y_view_reg <= 8'd0;
        end else begin
            run_reg    <= 1'b1;
            h_cnt_reg  <= h_cnt_next;
            v_cnt_reg  <= v_cnt_next;
            x_view_reg <= (int'(h_cnt_next) < H_ACTIVE) ? 8'(h_cnt_next) : 8'd0;
            y_view_reg <= (int'(v_cnt_next) < V_ACTIVE) ? 8'(v_cnt_next) : 8'd0;
        end
    end

    assign active_raw = run_reg && (int'(h_cnt_reg) < H_ACTIVE) && (int'(v_cnt_reg) < V_ACTIVE);
    assign hs_raw     = run_reg && (int'(h_cnt_reg) >= HS_BEG) && (int'(h_cnt_reg) < HS_END);
    assign vs_raw     = run_reg && (int'(v_cnt_reg) >= VS_BEG) && (int'(v_cnt_reg) < VS_END);

    // Timing flags travel alongside the ppu's own latency so they meet colour_in.
    generate
        for (genvar gi = 0; gi < PPU_LATENCY; gi++) begin : g_pipe
            logic [2:0] stage_in;
            logic [2:0] stage_reg;
            if (gi == 0) begin : g_first
                assign stage_in = {active_raw, hs_raw, vs_raw};
            end else begin : g_rest
                assign stage_in = g_pipe[gi-1].stage_reg;
            end
            always_ff @(posedge clk) begin
                if (clear) begin
                    stage_reg <= 3'b000;
                end else begin
                    stage_reg <= stage_in;
                end
            end
        end
    endgenerate

    assign pipe_out = g_pipe[PPU_LATENCY-1].stage_reg;

    always_ff @(posedge clk) begin
        if (clear) begin
            rgb_reg     <= 16'h0000;
            de_reg      <= 1'b0;
            hsync_n_reg <= 1'b1;
            vsync_n_reg <= 1'b1;
        end else begin
            rgb_reg     <= pipe_out[2] ? colour_in : 16'h0000;
            de_reg      <= pipe_out[2];
            hsync_n_reg <= ~pipe_out[1];
            vsync_n_reg <= ~pipe_out[0];
        end
    end

    assign x_view       = x_view_reg;
    assign y_view       = y_view_reg;
    assign rgb_out      = rgb_reg;
    assign de           = de_reg;
    assign hsync_n      = hsync_n_reg;
    assign vsync_n      = vsync_n_reg;
    assign vblank       = int'(v_cnt_reg) >= V_ACTIVE;
    assign vblank_start = run_reg && (h_cnt_reg == '0) && (int'(v_cnt_reg) == V_ACTIVE);

`ifdef PPU_LINE_IRQ_EN
    // Compared combinationally, so a new lyc is honoured from the next line start.
    assign line_irq = run_reg && (h_cnt_reg == '0) && (int'(v_cnt_reg) == int'(lyc));
`endif

endmodule

// File: tb/tb_ppu_video_timing.sv
// Bench for ppu_video_timing: raster model + ppu colour model, scoreboard for the delayed pixel stream.
`timescale 1ns/1ps
module tb_ppu_video_timing;
    localparam int L       = 3;
    localparam int H_ACT   = 160;
    localparam int V_ACT   = 144;
    localparam int H_TOTAL = 200;
    localparam int V_TOTAL = 156;
    localparam int HS_BEG  = 168;
    localparam int HS_END  = 184;
    localparam int VS_BEG  = 146;
    localparam int VS_END  = 148;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] colour_in;
    logic [7:0]  x_view, y_view;
    logic [15:0] rgb_out;
    logic        de, hsync_n, vsync_n, vblank, vblank_start;
`ifdef PPU_LINE_IRQ_EN
    logic [7:0]  lyc;
    logic        line_irq;
`endif

    always #5 clk = ~clk;

    ppu_video_timing dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .x_view       (x_view),
        .y_view       (y_view),
        .colour_in    (colour_in),
        .rgb_out      (rgb_out),
        .de           (de),
        .hsync_n      (hsync_n),
        .vsync_n      (vsync_n),
        .vblank       (vblank),
`ifdef PPU_LINE_IRQ_EN
        .lyc          (lyc),
        .line_irq     (line_irq),
`endif
        .vblank_start (vblank_start)
    );

    typedef struct {
        logic        de;
        logic        hs_n;
        logic        vs_n;
        logic [15:0] rgb;
    } disp_t;

    typedef struct {
        logic        rst_n;
        logic        en;
        int          ncyc;
        logic [7:0]  x;
        logic [7:0]  y;
        logic        de;
        logic        hs_n;
        logic        vs_n;
        logic        vb;
        logic [15:0] rgb;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    int          m_h   = 0;
    int          m_v   = 0;
    bit          m_run = 1'b0;
    disp_t       exp_q [$];
    logic [15:0] hist  [$];
    vec_t        vecs  [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (line %0d col %0d)", name, act, want, m_v, m_h);
        end
    endtask

    function automatic disp_t idle_rec();
        disp_t r;
        r.de   = 1'b0;
        r.hs_n = 1'b1;
        r.vs_n = 1'b1;
        r.rgb  = 16'h0000;
        return r;
    endfunction

    // One clock: advance model, check undelayed outputs, push/pop the display scoreboard, feed ppu colour.
    task automatic step();
        disp_t r;
        disp_t o;
        int    ex;
        int    ey;
        @(posedge clk);
        #1;
        if (!rst_n || !enable) begin
            m_run = 1'b0;
            m_h   = 0;
            m_v   = 0;
            hist.delete();
            exp_q.delete();
            for (int i = 0; i <= L; i++) exp_q.push_back(idle_rec());
        end else begin
            if (m_run) begin
                if (m_h == H_TOTAL - 1) begin
                    m_h = 0;
                    m_v = (m_v == V_TOTAL - 1) ? 0 : m_v + 1;
                end else begin
                    m_h++;
                end
            end
            m_run = 1'b1;
        end
        ex = (m_h < H_ACT) ? m_h : 0;
        ey = (m_v < V_ACT) ? m_v : 0;
        chk("x_view", 32'(x_view), 32'(ex));
        chk("y_view", 32'(y_view), 32'(ey));
        chk("vblank", 32'(vblank), 32'(m_v >= V_ACT));
        chk("vblank_start", 32'(vblank_start), 32'(m_run && m_h == 0 && m_v == V_ACT));
`ifdef PPU_LINE_IRQ_EN
        chk("line_irq", 32'(line_irq), 32'(m_run && m_h == 0 && m_v == int'(lyc)));
`endif
        r.de   = m_run && m_h < H_ACT && m_v < V_ACT;
        r.hs_n = !(m_run && m_h >= HS_BEG && m_h < HS_END);
        r.vs_n = !(m_run && m_v >= VS_BEG && m_v < VS_END);
        r.rgb  = r.de ? {8'(m_v), 8'(m_h)} : 16'h0000;
        exp_q.push_back(r);
        if (exp_q.size() > L + 1) begin
            o = exp_q.pop_front();
            chk("de", 32'(de), 32'(o.de));
            chk("hsync_n", 32'(hsync_n), 32'(o.hs_n));
            chk("vsync_n", 32'(vsync_n), 32'(o.vs_n));
            chk("rgb_out", 32'(rgb_out), 32'(o.rgb));
        end
        hist.push_back({y_view, x_view});
        if (hist.size() > L) colour_in = hist.pop_front();
        else colour_in = 16'hBEEF;
    endtask

    task automatic add(input logic rs, input logic en, input int n, input logic [7:0] x,
                       input logic [7:0] y, input logic d, input logic hs, input logic vs,
                       input logic vb, input logic [15:0] rgb);
        vec_t v;
        v.rst_n = rs; v.en = en; v.ncyc = n; v.x = x; v.y = y;
        v.de = d; v.hs_n = hs; v.vs_n = vs; v.vb = vb; v.rgb = rgb;
        vecs.push_back(v);
    endtask

    initial begin
        int   n_de, n_hs_fall, n_hs_fall_act, n_vs_low, n_vb, n_vbs, n_irq, run_len;
        logic prev_hs;

        rst_n     = 1'b0;
        enable    = 1'b1;
        colour_in = 16'h0000;
`ifdef PPU_LINE_IRQ_EN
        lyc       = 8'd10;
`endif
        //   rst en  cycles  x      y      de hs vs vb rgb
        add(0, 1, 3,     8'd0,  8'd0,  0, 1, 1, 0, 16'h0000);
        add(1, 1, 1,     8'd0,  8'd0,  0, 1, 1, 0, 16'h0000);
        add(1, 1, 4,     8'd4,  8'd0,  1, 1, 1, 0, 16'h0000);
        add(1, 1, 1,     8'd5,  8'd0,  1, 1, 1, 0, 16'h0001);
        add(1, 1, 158,   8'd0,  8'd0,  1, 1, 1, 0, 16'h009F);
        add(1, 1, 1,     8'd0,  8'd0,  0, 1, 1, 0, 16'h0000);
        add(1, 1, 8,     8'd0,  8'd0,  0, 0, 1, 0, 16'h0000);
        add(1, 1, 15,    8'd0,  8'd0,  0, 0, 1, 0, 16'h0000);
        add(1, 1, 1,     8'd0,  8'd0,  0, 1, 1, 0, 16'h0000);
        add(1, 1, 17,    8'd5,  8'd1,  1, 1, 1, 0, 16'h0101);
        add(1, 1, 28595, 8'd0,  8'd0,  0, 1, 1, 1, 16'h0000);
        add(1, 1, 404,   8'd4,  8'd0,  0, 1, 0, 1, 16'h0000);
        add(1, 1, 399,   8'd3,  8'd0,  0, 1, 0, 1, 16'h0000);
        add(1, 1, 1,     8'd4,  8'd0,  0, 1, 1, 1, 16'h0000);
        add(1, 1, 1595,  8'd0,  8'd0,  0, 1, 1, 1, 16'h0000);
        add(1, 1, 1,     8'd0,  8'd0,  0, 1, 1, 0, 16'h0000);
        add(1, 1, 1,     8'd1,  8'd0,  0, 1, 1, 0, 16'h0000);
        add(1, 1, 10069, 8'd70, 8'd50, 1, 1, 1, 0, 16'h3242);
        add(1, 0, 1,     8'd0,  8'd0,  0, 1, 1, 0, 16'h0000);
        add(1, 0, 4,     8'd0,  8'd0,  0, 1, 1, 0, 16'h0000);
        add(1, 1, 1,     8'd0,  8'd0,  0, 1, 1, 0, 16'h0000);
        add(1, 1, 4,     8'd4,  8'd0,  1, 1, 1, 0, 16'h0000);
        add(1, 1, 1,     8'd5,  8'd0,  1, 1, 1, 0, 16'h0001);

        foreach (vecs[i]) begin
            rst_n  = vecs[i].rst_n;
            enable = vecs[i].en;
            repeat (vecs[i].ncyc) step();
            chk($sformatf("v%0d.x_view", i),  32'(x_view),  32'(vecs[i].x));
            chk($sformatf("v%0d.y_view", i),  32'(y_view),  32'(vecs[i].y));
            chk($sformatf("v%0d.de", i),      32'(de),      32'(vecs[i].de));
            chk($sformatf("v%0d.hsync_n", i), 32'(hsync_n), 32'(vecs[i].hs_n));
            chk($sformatf("v%0d.vsync_n", i), 32'(vsync_n), 32'(vecs[i].vs_n));
            chk($sformatf("v%0d.vblank", i),  32'(vblank),  32'(vecs[i].vb));
            chk($sformatf("v%0d.rgb_out", i), 32'(rgb_out), 32'(vecs[i].rgb));
            $display("vec %0d: rst_n=%b en=%b cyc=%0d x=%0d y=%0d de=%b hs_n=%b vs_n=%b vb=%b rgb=%h",
                     i, rst_n, enable, vecs[i].ncyc, x_view, y_view, de, hsync_n, vsync_n, vblank, rgb_out);
        end

        // One full output period in steady state: count pixel, sync and blank events.
        n_de = 0; n_hs_fall = 0; n_hs_fall_act = 0; n_vs_low = 0;
        n_vb = 0; n_vbs = 0; n_irq = 0; run_len = 0;
        prev_hs = hsync_n;
        repeat (H_TOTAL * V_TOTAL) begin
            step();
            if (de) n_de++;
            if (!vsync_n) n_vs_low++;
            if (vblank) n_vb++;
            if (vblank_start) n_vbs++;
`ifdef PPU_LINE_IRQ_EN
            if (line_irq) n_irq++;
`endif
            if (prev_hs && !hsync_n) begin
                n_hs_fall++;
                if (!vblank) n_hs_fall_act++;
                run_len = 0;
            end
            if (!hsync_n) run_len++;
            if (!prev_hs && hsync_n) chk("hsync_width", 32'(run_len), 32'd16);
            prev_hs = hsync_n;
        end
        chk("frame.de_count", 32'(n_de), 32'(H_ACT * V_ACT));
        chk("frame.hsync_pulses", 32'(n_hs_fall), 32'(V_TOTAL));
        chk("frame.hsync_active", 32'(n_hs_fall_act), 32'(V_ACT));
        chk("frame.vsync_low", 32'(n_vs_low), 32'(2 * H_TOTAL));
        chk("frame.vblank_clks", 32'(n_vb), 32'((V_TOTAL - V_ACT) * H_TOTAL));
        chk("frame.vblank_start", 32'(n_vbs), 32'd1);
`ifdef PPU_LINE_IRQ_EN
        chk("frame.line_irq", 32'(n_irq), 32'd1);
`endif
        $display("frame: de=%0d hs_pulses=%0d hs_active=%0d vs_low=%0d vblank=%0d vblank_start=%0d",
                 n_de, n_hs_fall, n_hs_fall_act, n_vs_low, n_vb, n_vbs);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
